// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the single-bus CPU control unit.
// Provides the opcode and ALU-code constants, the sequencer state encoding,
// the opcode-class encoding and a helper that maps an opcode to its class.
package cpu_ctrl_pkg;

  localparam logic [4:0] OpLd    = 5'b00000;
  localparam logic [4:0] OpLdi   = 5'b00001;
  localparam logic [4:0] OpSt    = 5'b00010;
  localparam logic [4:0] OpAluLo = 5'b00011;
  localparam logic [4:0] OpAluHi = 5'b01011;
  localparam logic [4:0] OpAddi  = 5'b01100;
  localparam logic [4:0] OpAndi  = 5'b01101;
  localparam logic [4:0] OpOri   = 5'b01110;
  localparam logic [4:0] OpBr    = 5'b10010;
  localparam logic [4:0] OpJr    = 5'b10011;
  localparam logic [4:0] OpNop   = 5'b11010;
  localparam logic [4:0] OpHalt  = 5'b11011;

  localparam logic [4:0] AluAdd = 5'b00011;
  localparam logic [4:0] AluAnd = 5'b00101;
  localparam logic [4:0] AluOr  = 5'b00110;

  typedef enum logic [3:0] {
    RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_e;

  typedef enum logic [3:0] {
    ClsAlu, ClsImm, ClsLdi, ClsLd, ClsSt, ClsBr, ClsJr, ClsNop, ClsHalt, ClsIllegal
  } op_class_e;

  function automatic op_class_e decode_class(input logic [4:0] op);
    op_class_e cls;
    if (op >= OpAluLo && op <= OpAluHi) begin
      cls = ClsAlu;
    end else begin
      case (op)
        OpLd:                  cls = ClsLd;
        OpLdi:                 cls = ClsLdi;
        OpSt:                  cls = ClsSt;
        OpAddi, OpAndi, OpOri: cls = ClsImm;
        OpBr:                  cls = ClsBr;
        OpJr:                  cls = ClsJr;
        OpNop:                 cls = ClsNop;
        OpHalt:                cls = ClsHalt;
        default:               cls = ClsIllegal;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bundle of every signal between the control unit and the datapath.
// master: control unit (reads IR/conOut/stop, drives strobes and status).
// slave:  datapath / environment (drives IR/conOut/stop, reads strobes).
interface control_unit_if;
  logic [31:0] IR;
  logic        conOut;
  logic        stop;

  logic PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin, ZLOin, ZLOout, CSignout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, conin;
  logic read, write, RAMenable;
  logic [4:0] aluControl;
  logic run;
  logic illegal;

  modport master (
    input  IR, conOut, stop,
    output PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin, ZLOin, ZLOout, CSignout,
    output Gra, Grb, Grc, Rin, Rout, BAout, conin,
    output read, write, RAMenable, aluControl, run, illegal
  );

  modport slave (
    output IR, conOut, stop,
    input  PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin, ZLOin, ZLOout, CSignout,
    input  Gra, Grb, Grc, Rin, Rout, BAout, conin,
    input  read, write, RAMenable, aluControl, run, illegal
  );
endinterface

// File: rtl/ctrl_opdecode.sv
// Combinational opcode decoder.
// opcode_i   : IR[31:27]
// op_class_o : execute-sequence class of the instruction
// alu_code_o : ALU operation used by the instruction's add/logic step
module ctrl_opdecode
  import cpu_ctrl_pkg::*;
#(
  parameter logic [4:0] ALU_ADD = 5'b00011
) (
  input  logic [4:0] opcode_i,
  output op_class_e  op_class_o,
  output logic [4:0] alu_code_o
);

  assign op_class_o = decode_class(opcode_i);

  always_comb begin
    alu_code_o = 5'b00000;
    case (op_class_o)
      ClsAlu: alu_code_o = opcode_i;
      ClsImm: begin
        case (opcode_i)
          OpAndi:  alu_code_o = AluAnd;
          OpOri:   alu_code_o = AluOr;
          default: alu_code_o = AluAdd;
        endcase
      end
      // Effective-address and branch-target adds.
      ClsLdi, ClsLd, ClsSt, ClsBr: alu_code_o = ALU_ADD;
      default: alu_code_o = 5'b00000;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer for the single-bus CPU datapath.
// clock : rising-edge clock
// clear : asynchronous active-high reset, forces RESET
// cu    : datapath bundle (IR, conOut, stop in; strobes, aluControl, run, illegal out)
// Outputs are a Moore decode of the state register; the only exceptions are the
// T0 strobes (suppressed when stop is seen) and PCin in the branch T6 step (conOut).
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter logic [4:0]  ALU_ADD  = 5'b00011
) (
  input  logic           clock,
  input  logic           clear,
  control_unit_if.master cu
);

  localparam logic [2:0] MemWaitLd = 3'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  op_class_e  op_class;
  logic [4:0] alu_code;

  ctrl_opdecode #(
    .ALU_ADD(ALU_ADD)
  ) u_opdecode (
    .opcode_i  (cu.IR[31:27]),
    .op_class_o(op_class),
    .alu_code_o(alu_code)
  );

  // Next state. Memory steps (T1, ld T6, st T7) load the wait counter on entry
  // and only advance once it has counted down to zero.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    case (state_q)
      RESET: state_d = T0;
      T0: begin
        if (cu.stop) begin
          state_d = HALT;
        end else begin
          state_d = T1;
          wait_d  = MemWaitLd;
        end
      end
      T1: begin
        if (wait_q == 3'd0) state_d = T2;
        else                wait_d  = wait_q - 3'd1;
      end
      T2: begin
        case (op_class)
          ClsNop:  state_d = T0;
          ClsHalt: state_d = HALT;
          ClsIllegal: begin
            state_d   = HALT;
            illegal_d = 1'b1;
          end
          default: state_d = T3;
        endcase
      end
      T3: state_d = (op_class == ClsJr) ? T0 : T4;
      T4: state_d = T5;
      T5: begin
        if (op_class == ClsLd || op_class == ClsSt || op_class == ClsBr) begin
          state_d = T6;
          if (op_class == ClsLd) wait_d = MemWaitLd;
        end else begin
          state_d = T0;
        end
      end
      T6: begin
        if (op_class == ClsLd) begin
          if (wait_q == 3'd0) state_d = T7;
          else                wait_d  = wait_q - 3'd1;
        end else if (op_class == ClsSt) begin
          state_d = T7;
          wait_d  = MemWaitLd;
        end else begin
          state_d = T0;
        end
      end
      T7: begin
        if (op_class == ClsSt && wait_q != 3'd0) wait_d  = wait_q - 3'd1;
        else                                     state_d = T0;
      end
      HALT:    state_d = HALT;
      default: state_d = RESET;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= RESET;
      wait_q    <= 3'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    {cu.PCout, cu.IncPC, cu.PCin, cu.MARin, cu.MDRin, cu.MDRout, cu.IRin} = '0;
    {cu.Yin, cu.ZLOin, cu.ZLOout, cu.CSignout} = '0;
    {cu.Gra, cu.Grb, cu.Grc, cu.Rin, cu.Rout, cu.BAout, cu.conin} = '0;
    {cu.read, cu.write, cu.RAMenable} = '0;
    cu.aluControl = 5'b00000;
    cu.run        = (state_q != RESET) && (state_q != HALT);
    cu.illegal    = illegal_q;
    case (state_q)
      T0: begin
        // A pending stop turns this T0 into a silent step towards HALT.
        if (!cu.stop) {cu.PCout, cu.MARin, cu.IncPC} = 3'b111;
      end
      T1: {cu.read, cu.RAMenable, cu.MDRin} = 3'b111;
      T2: {cu.MDRout, cu.IRin} = 2'b11;
      T3: begin
        case (op_class)
          ClsAlu, ClsImm:      {cu.Grb, cu.Rout, cu.Yin} = 3'b111;
          ClsLdi, ClsLd, ClsSt: {cu.Grb, cu.BAout, cu.Yin} = 3'b111;
          ClsBr:               {cu.Gra, cu.Rout, cu.conin} = 3'b111;
          ClsJr:               {cu.Gra, cu.Rout, cu.PCin} = 3'b111;
          default: ;
        endcase
      end
      T4: begin
        case (op_class)
          ClsAlu: begin
            {cu.Grc, cu.Rout, cu.ZLOin} = 3'b111;
            cu.aluControl = alu_code;
          end
          ClsImm, ClsLdi, ClsLd, ClsSt: begin
            {cu.CSignout, cu.ZLOin} = 2'b11;
            cu.aluControl = alu_code;
          end
          ClsBr:   {cu.PCout, cu.Yin} = 2'b11;
          default: ;
        endcase
      end
      T5: begin
        case (op_class)
          ClsAlu, ClsImm, ClsLdi: {cu.ZLOout, cu.Gra, cu.Rin} = 3'b111;
          ClsLd, ClsSt:           {cu.ZLOout, cu.MARin} = 2'b11;
          ClsBr: begin
            {cu.CSignout, cu.ZLOin} = 2'b11;
            cu.aluControl = alu_code;
          end
          default: ;
        endcase
      end
      T6: begin
        case (op_class)
          ClsLd: {cu.read, cu.RAMenable, cu.MDRin} = 3'b111;
          ClsSt: {cu.Gra, cu.Rout, cu.MDRin} = 3'b111;
          ClsBr: begin
            cu.ZLOout = 1'b1;
            cu.PCin   = cu.conOut;
          end
          default: ;
        endcase
      end
      T7: begin
        case (op_class)
          ClsLd:   {cu.MDRout, cu.Gra, cu.Rin} = 3'b111;
          ClsSt:   {cu.write, cu.RAMenable} = 2'b11;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired FSM sequencer that drives every control input of the single-bus CPU datapath.
- Runs fetch, decode and execute for a fixed instruction subset. Reads the IR opcode and the CON flip-flop output, and emits one-cycle control strobes per T-step.
- Sits beside the datapath at the CPU top level and replaces the testbench-driven control signals.

Parameters:
- MEM_WAIT, 0: extra wait cycles held in each RAM read/write step (0..7).
- ALU_ADD, 5'b00011: aluControl code used for address and branch-offset adds.

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous active-high reset
- IR  in  32  instruction register contents; opcode is IR[31:27]
- conOut  in  1  branch condition from CON FF
- stop  in  1  halt request, sampled at T0
- PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin, ZLOin, ZLOout, CSignout  out  1 each  datapath strobes
- Gra, Grb, Grc, Rin, Rout, BAout, conin  out  1 each  select/encode and CON strobes
- read, write, RAMenable  out  1 each  memory controls
- aluControl  out  5  ALU operation
- run  out  1  high while executing
- illegal  out  1  sticky: an undefined opcode was decoded

Behaviour:
- Reset: clear=1 forces state RESET asynchronously. All strobes, aluControl, run and illegal go to 0. One cycle after clear falls, the FSM moves RESET->T0.
- Outputs are decoded from the state register (Moore). Every strobe not listed for a state is 0, and aluControl is 0 unless listed.
- T0: PCout, MARin, IncPC. If stop=1 here, go to HALT instead and assert none of these strobes.
- T1: read, RAMenable, MDRin. Hold for MEM_WAIT extra cycles using a 3-bit wait counter. The counter is loaded on entry and the FSM advances when it reaches 0.
- T2: MDRout, IRin.
- T3 onward depends on the opcode class:
  - ALU R-type (opcodes 00011..01011):
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, ZLOin, aluControl=opcode.
    - T5: ZLOout, Gra, Rin. Then T0.
  - Immediate (addi 01100, andi 01101, ori 01110):
    - T3: Grb, Rout, Yin.
    - T4: CSignout, ZLOin, aluControl = add/and/or code (00011/00101/00110).
    - T5: ZLOout, Gra, Rin.
  - ldi 00001: T3 Grb, BAout, Yin; T4 CSignout, ZLOin, ALU_ADD; T5 ZLOout, Gra, Rin.
  - ld 00000:
    - T3..T4 as ldi.
    - T5: ZLOout, MARin.
    - T6: read, RAMenable, MDRin (+MEM_WAIT).
    - T7: MDRout, Gra, Rin.
  - st 00010:
    - T3..T5 as ld.
    - T6: Gra, Rout, MDRin (read=0).
    - T7: write, RAMenable (+MEM_WAIT).
  - branch 10010:
    - T3: Gra, Rout, conin.
    - T4: PCout, Yin.
    - T5: CSignout, ZLOin, ALU_ADD.
    - T6: ZLOout, plus PCin only if conOut=1 (sampled in T6).
  - jr 10011: T3 Gra, Rout, PCin.
  - nop 11010: return to T0 directly after T2.
  - halt 11011: go to HALT.
  - Any other opcode: set illegal=1 and go to HALT.
- Every final execute step returns to T0.
- HALT: all strobes 0, run=0. Only clear exits HALT.
- run=1 in all states except RESET and HALT.
- clear during any state, including mid memory wait, aborts immediately. No partial write is held: write and RAMenable drop asynchronously.
- stop asserted outside T0 is ignored until the next T0. The current instruction always completes.
- Cycle counts, fetch inclusive, at MEM_WAIT=0: ALU/imm/ldi 6, ld/st 8, branch 7, jr 4, nop 3.

Decomposition:
- Package cpu_ctrl_pkg: opcode localparams, ALU code localparams, state enum (RESET, T0..T7, HALT), opcode-class decode function.
- One natural sub-module: ctrl_opdecode, a combinational map from opcode to class and ALU code. The FSM stays in control_unit.

Test Plan:
- Reset then run: clear pulse, IR=add r1,r2,r3 (opcode 00011) -> T0 strobes 1 cycle after release. Exact strobe sequence over 6 cycles. T4 aluControl=00011. run=1.
- ld with MEM_WAIT=2: opcode 00000 -> read/RAMenable/MDRin held 3 cycles in both T1 and T6. Total 12 cycles. Gra/Rin in the final cycle only.
- st: opcode 00010 -> write=1 and RAMenable=1 in T7 only. write is never asserted in any other state.
- Branch taken/not taken: opcode 10010 with conOut=1 -> PCin in T6. Repeat with conOut=0 -> PCin stays 0 throughout. Both take 7 cycles.
- Halt/stop/illegal:
  - opcode 11011 -> HALT, run=0, outputs frozen at 0 for 20 cycles.
  - stop=1 during T4 of an add -> add completes, HALT entered at the next T0.
  - opcode 11111 -> illegal=1, HALT.
- Async abort: clear raised mid-T7 of st (MEM_WAIT=3) -> write drops the same cycle with no clock edge. RESET->T0 after release.
